// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// instruction classes, datapath select codes and opcode/funct constants.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_ITYPE   = 4'd1,
    C_LOAD    = 4'd2,
    C_STORE   = 4'd3,
    C_BEQ     = 4'd4,
    C_J       = 4'd5,
    C_JAL     = 4'd6,
    C_JR      = 4'd7,
    C_ILLEGAL = 4'd8
  } inst_class_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_JR   = 6'b001000;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decode: op/funct to instruction class plus the
// ALU-side controls (operation, immediate extension, operand B select).
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output inst_class_t inst_class,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic        alu_src
);

  always_comb begin
    inst_class = C_ILLEGAL;
    alu_op     = ALU_ADD;
    ext_op     = EXT_ZERO;
    alu_src    = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU: begin inst_class = C_RTYPE; alu_op = ALU_ADD; end
          F_SUBU: begin inst_class = C_RTYPE; alu_op = ALU_SUB; end
          F_AND:  begin inst_class = C_RTYPE; alu_op = ALU_AND; end
          F_OR:   begin inst_class = C_RTYPE; alu_op = ALU_OR;  end
          F_SLT:  begin inst_class = C_RTYPE; alu_op = ALU_SLT; end
          F_JR:   inst_class = C_JR;
          default: inst_class = C_ILLEGAL;
        endcase
      end
      OP_ADDIU: begin
        inst_class = C_ITYPE;
        alu_op     = ALU_ADD;
        ext_op     = EXT_SIGN;
        alu_src    = 1'b1;
      end
      OP_ORI: begin
        inst_class = C_ITYPE;
        alu_op     = ALU_OR;
        ext_op     = EXT_ZERO;
        alu_src    = 1'b1;
      end
      // rs is $0 for lui, so OR-ing the upper-extended immediate yields it unchanged
      OP_LUI: begin
        inst_class = C_ITYPE;
        alu_op     = ALU_OR;
        ext_op     = EXT_UPPER;
        alu_src    = 1'b1;
      end
      OP_LW: begin
        inst_class = C_LOAD;
        alu_op     = ALU_ADD;
        ext_op     = EXT_SIGN;
        alu_src    = 1'b1;
      end
      OP_SW: begin
        inst_class = C_STORE;
        alu_op     = ALU_ADD;
        ext_op     = EXT_SIGN;
        alu_src    = 1'b1;
      end
      OP_BEQ: begin
        inst_class = C_BEQ;
        alu_op     = ALU_SUB;
        ext_op     = EXT_SIGN;
        alu_src    = 1'b0;
      end
      OP_J:    inst_class = C_J;
      OP_JAL:  inst_class = C_JAL;
      default: inst_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS datapath: steps each instruction
// through FETCH/DCD/EXE/MEM/WB and counts retired instructions.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             dm_ready,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             ir_wr,
  output logic             rf_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [1:0]       ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             dm_rd,
  output logic             dm_wr,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  state_t      state_q;
  state_t      state_d;
  inst_class_t inst_class;
  logic [2:0]  dec_alu_op;
  logic [1:0]  dec_ext_op;
  logic        dec_alu_src;
  logic        retire;

  mc_decode u_decode (
    .op         (op),
    .funct      (funct),
    .inst_class (inst_class),
    .alu_op     (dec_alu_op),
    .ext_op     (dec_ext_op),
    .alu_src    (dec_alu_src)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        case (inst_class)
          C_J, C_JAL, C_JR, C_ILLEGAL: state_d = S_FETCH;
          default:                     state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (inst_class)
          C_BEQ:          state_d = S_FETCH;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dm_ready) state_d = (inst_class == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Memory handshake: dm_rd/dm_wr stay high every MEM cycle until the memory
  // answers dm_ready=1 in a cycle where the request is up; that cycle completes
  // the access (same-cycle ready means zero wait). dm_ready is ignored elsewhere.
  always_comb begin
    pc_wr   = 1'b0;
    npc_sel = NPC_SEQ;
    ir_wr   = 1'b0;
    rf_wr   = 1'b0;
    reg_dst = REG_DST_RT;
    wd_sel  = WD_ALU;
    ext_op  = EXT_ZERO;
    alu_src = 1'b0;
    alu_op  = ALU_ADD;
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    illegal = 1'b0;
    if (!rst) begin
      if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
        ext_op  = dec_ext_op;
        alu_src = dec_alu_src;
        alu_op  = dec_alu_op;
      end
      case (state_q)
        S_FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        S_DCD: begin
          case (inst_class)
            C_J: begin
              pc_wr   = 1'b1;
              npc_sel = NPC_JUMP;
            end
            // PC already holds PC+4 from FETCH, which is the link value
            C_JAL: begin
              pc_wr   = 1'b1;
              npc_sel = NPC_JUMP;
              rf_wr   = 1'b1;
              reg_dst = REG_DST_R31;
              wd_sel  = WD_PC;
            end
            C_JR: begin
              pc_wr   = 1'b1;
              npc_sel = NPC_JR;
            end
            C_ILLEGAL: illegal = 1'b1;
            default: ;
          endcase
        end
        S_EXE: begin
          if (inst_class == C_BEQ) begin
            pc_wr   = zero;
            npc_sel = NPC_BRANCH;
          end
        end
        S_MEM: begin
          dm_rd = (inst_class == C_LOAD);
          dm_wr = (inst_class == C_STORE);
        end
        S_WB: begin
          rf_wr = 1'b1;
          case (inst_class)
            C_LOAD: begin
              reg_dst = REG_DST_RT;
              wd_sel  = WD_DM;
            end
            C_RTYPE: begin
              reg_dst = REG_DST_RD;
              wd_sel  = WD_ALU;
            end
            default: begin
              reg_dst = REG_DST_RT;
              wd_sel  = WD_ALU;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign retire = (state_q != S_FETCH) && (state_d == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst)         retired <= '0;
    else if (retire) retired <= retired + CNT_W'(1);
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus a randomized
// instruction stream checked cycle by cycle against a per-instruction model.
module tb_mc_ctrl;

  localparam int TB_CNT_W = 4;
  localparam int W = 21;
  localparam logic [W-1:0] ALU_MASK = 21'h0001F8;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [5:0]          op;
  logic [5:0]          funct;
  logic                zero;
  logic                dm_ready;
  logic                pc_wr;
  logic [1:0]          npc_sel;
  logic                ir_wr;
  logic                rf_wr;
  logic [1:0]          reg_dst;
  logic [1:0]          wd_sel;
  logic [1:0]          ext_op;
  logic                alu_src;
  logic [2:0]          alu_op;
  logic                dm_rd;
  logic                dm_wr;
  logic                illegal;
  logic [TB_CNT_W-1:0] retired;
  logic [2:0]          state;
  logic [W-1:0]        obs;

  logic [W-1:0]        exp_q[$];
  logic [TB_CNT_W-1:0] exp_retired;
  int checks = 0;
  int errors = 0;

  mc_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .dm_ready(dm_ready), .pc_wr(pc_wr), .npc_sel(npc_sel), .ir_wr(ir_wr),
    .rf_wr(rf_wr), .reg_dst(reg_dst), .wd_sel(wd_sel), .ext_op(ext_op),
    .alu_src(alu_src), .alu_op(alu_op), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .illegal(illegal), .retired(retired), .state(state)
  );

  assign obs = {state, pc_wr, npc_sel, ir_wr, rf_wr, reg_dst, wd_sel,
                ext_op, alu_src, alu_op, dm_rd, dm_wr, illegal};

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: begin
        case (f)
          6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010: return K_R;
          6'b001000: return K_JR;
          default:   return K_ILL;
        endcase
      end
      6'b001001, 6'b001101, 6'b001111: return K_I;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // {ext_op, alu_src, alu_op} the datapath needs for this instruction
  function automatic logic [5:0] alu_fields(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: begin
        case (f)
          6'b100011: return {2'd0, 1'b0, 3'd1};
          6'b100100: return {2'd0, 1'b0, 3'd2};
          6'b100101: return {2'd0, 1'b0, 3'd3};
          6'b101010: return {2'd0, 1'b0, 3'd4};
          default:   return {2'd0, 1'b0, 3'd0};
        endcase
      end
      6'b001001: return {2'd1, 1'b1, 3'd0};
      6'b001101: return {2'd0, 1'b1, 3'd3};
      6'b001111: return {2'd2, 1'b1, 3'd3};
      6'b100011, 6'b101011: return {2'd1, 1'b1, 3'd0};
      6'b000100: return {2'd1, 1'b0, 3'd1};
      default:   return 6'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] pk(input int st, input bit pcw, input int npc,
                                      input bit irw, input bit rfw, input int rd,
                                      input int wd, input logic [5:0] alu,
                                      input bit mrd, input bit mwr, input bit ill);
    return {3'(st), pcw, 2'(npc), irw, rfw, 2'(rd), 2'(wd), alu, mrd, mwr, ill};
  endfunction

  function automatic void push_instr(input logic [5:0] o, input logic [5:0] f,
                                     input bit z, input int waits);
    int k;
    logic [5:0] a;
    k = classify(o, f);
    a = alu_fields(o, f);
    exp_q.push_back(pk(0, 1, 0, 1, 0, 0, 0, 6'd0, 0, 0, 0));
    case (k)
      K_J:   exp_q.push_back(pk(1, 1, 2, 0, 0, 0, 0, 6'd0, 0, 0, 0));
      K_JAL: exp_q.push_back(pk(1, 1, 2, 0, 1, 2, 2, 6'd0, 0, 0, 0));
      K_JR:  exp_q.push_back(pk(1, 1, 3, 0, 0, 0, 0, 6'd0, 0, 0, 0));
      K_ILL: exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 1));
      default: begin
        exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 6'd0, 0, 0, 0));
        if (k == K_BEQ) exp_q.push_back(pk(2, z, 1, 0, 0, 0, 0, a, 0, 0, 0));
        else            exp_q.push_back(pk(2, 0, 0, 0, 0, 0, 0, a, 0, 0, 0));
        if (k == K_LW || k == K_SW)
          for (int i = 0; i <= waits; i++)
            exp_q.push_back(pk(3, 0, 0, 0, 0, 0, 0, a, k == K_LW, k == K_SW, 0));
        if (k == K_LW) exp_q.push_back(pk(4, 0, 0, 0, 1, 0, 1, a, 0, 0, 0));
        if (k == K_R)  exp_q.push_back(pk(4, 0, 0, 0, 1, 1, 0, a, 0, 0, 0));
        if (k == K_I)  exp_q.push_back(pk(4, 0, 0, 0, 1, 0, 0, a, 0, 0, 0));
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Entered just after a rising edge with the DUT in FETCH and rst low.
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input bit z, input int waits);
    logic [W-1:0] exp_v;
    logic [W-1:0] got;
    int mem_cnt = 0;
    int cyc = 0;
    push_instr(o, f, z, waits);
    op = o;
    funct = f;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      zero = (exp_v[20:18] == 3'd2) ? z : 1'($urandom_range(0, 1));
      if (exp_v[20:18] == 3'd3) begin
        dm_ready = (mem_cnt == waits);
        mem_cnt++;
      end else begin
        dm_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      got = obs;
      if (exp_v[20:18] != 3'd2 && exp_v[20:18] != 3'd3) begin
        got   = got & ~ALU_MASK;
        exp_v = exp_v & ~ALU_MASK;
      end
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %h expected %h", name, cyc, got, exp_v);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
    exp_retired = exp_retired + 1'b1;
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL %s retired: got %0d expected %0d", name, retired, exp_retired);
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL %s end state: got %0d expected 0", name, state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      op       = 6'($urandom_range(0, 63));
      funct    = 6'($urandom_range(0, 63));
      zero     = 1'($urandom_range(0, 1));
      dm_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset outputs: got %h expected 0", obs);
      end
      checks++;
      if (retired !== '0) begin
        errors++;
        $display("FAIL reset retired: got %0d expected 0", retired);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_retired = '0;
    #1;
    checks++;
    if ({ir_wr, pc_wr, state} !== {1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL first fetch: got ir_wr=%b pc_wr=%b state=%0d expected 1 1 0",
               ir_wr, pc_wr, state);
    end
  endtask

  task automatic test_addu();
    run_instr("addu", 6'b000000, 6'b100001, 1'b0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait3", 6'b100011, 6'($urandom_range(0, 63)), 1'b0, 3);
    run_instr("sw_nowait", 6'b101011, 6'($urandom_range(0, 63)), 1'b0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'b000100, 6'($urandom_range(0, 63)), 1'b1, 0);
    run_instr("beq_not_taken", 6'b000100, 6'($urandom_range(0, 63)), 1'b0, 0);
  endtask

  task automatic test_jal_illegal();
    run_instr("jal", 6'b000011, 6'($urandom_range(0, 63)), 1'b0, 0);
    run_instr("illegal_op", 6'b111111, 6'($urandom_range(0, 63)), 1'b0, 0);
    run_instr("illegal_funct", 6'b000000, 6'b000000, 1'b0, 0);
    run_instr("jr", 6'b000000, 6'b001000, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[14]   = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09,
                              6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [5:0] functs[6] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h08};
    logic [5:0] o;
    logic [5:0] f;
    int idx;
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 15);
      if (idx < 14) begin
        o = ops[idx];
        f = (idx < 6) ? functs[idx] : 6'($urandom_range(0, 63));
      end else begin
        do begin
          o = (idx == 14) ? 6'($urandom_range(0, 63)) : 6'd0;
          f = 6'($urandom_range(0, 63));
        end while (classify(o, f) != K_ILL);
      end
      run_instr("random", o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid_sw();
    op = 6'b101011;
    funct = 6'd0;
    dm_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if ({state, dm_wr, retired} !== {3'd3, 1'b1, exp_retired}) begin
      errors++;
      $display("FAIL sw_wait: got state=%0d dm_wr=%b retired=%0d expected 3 1 %0d",
               state, dm_wr, retired, exp_retired);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({dm_wr, retired} !== {1'b0, exp_retired}) begin
      errors++;
      $display("FAIL sw_abort: got dm_wr=%b retired=%0d expected 0 %0d",
               dm_wr, retired, exp_retired);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({state, retired} !== {3'd0, TB_CNT_W'(0)}) begin
      errors++;
      $display("FAIL sw_abort_reset: got state=%0d retired=%0d expected 0 0", state, retired);
    end
    rst = 1'b0;
    exp_retired = '0;
    run_instr("after_abort_ori", 6'b001101, 6'd0, 1'b0, 0);
  endtask

  initial begin
    rst = 1'b1;
    op = '0;
    funct = '0;
    zero = 1'b0;
    dm_ready = 1'b0;
    exp_retired = '0;
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal_illegal();
    test_back_to_back();
    test_reset();
    test_reset_mid_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS datapath. It replaces the single-cycle combinational signal decoder with a registered FSM. Each instruction is stepped through FETCH/DCD/EXE/MEM/WB, so PC, IR, register file, ALU and data memory are shared across cycles. Data-memory accesses use a ready handshake, so `dm_4k` or a slower memory can insert wait states.

## Interface
- `CNT_W`, 32: width of retired-instruction counter `retired`.
- `clk` in 1: system clock, all state updates on rising edge.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `op` in 6: IR[31:26]; valid from DCD onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, sampled in EXE.
- `dm_ready` in 1: data memory completes access this cycle.
- `pc_wr` out 1: PC load enable.
- `npc_sel` out 2: 0=PC+4, 1=branch (PC+4+Imm32<<2), 2=jump (PC[31:28],IMM,00), 3=jr (RD1).
- `ir_wr` out 1: instruction register load.
- `rf_wr` out 1: register-file write.
- `reg_dst` out 2: 0=rt, 1=rd, 2=r31.
- `wd_sel` out 2: 0=ALU result, 1=DM_Out, 2=PC (link).
- `ext_op` out 2: 0=zero, 1=sign, 2=upper (lui).
- `alu_src` out 1: 0=RD2, 1=Imm32.
- `alu_op` out 3: see package.
- `dm_rd`, `dm_wr` out 1 each: data memory request, held until `dm_ready`.
- `illegal` out 1: one-cycle pulse on an undecoded op/funct.
- `retired` out CNT_W: count of completed instructions.
- `state` out 3: current FSM state, for debug.

## Operation
- States: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. Outputs are combinational from registered `state`, `op` and `funct`.
- Supported instructions:
  - R-type (op 000000): addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000.
  - I/J-type: addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH: `ir_wr`=1, `pc_wr`=1, `npc_sel`=0. Next state DCD.
- DCD:
  - j: `pc_wr`=1, `npc_sel`=2, go to FETCH.
  - jal: same, plus `rf_wr`=1, `reg_dst`=2, `wd_sel`=2 (PC already +4). Go to FETCH.
  - jr: `pc_wr`=1, `npc_sel`=3, go to FETCH.
  - Illegal: `illegal`=1, go to FETCH; acts as a nop.
  - Else go to EXE.
- EXE: `alu_src`/`alu_op`/`ext_op` come from the decode.
  - beq: `alu_op`=SUB, `pc_wr`=`zero`, `npc_sel`=1, go to FETCH.
  - lw/sw: ADD with sign-extended immediate, go to MEM.
  - All others go to WB.
- MEM:
  - `dm_rd` (lw) or `dm_wr` (sw) is asserted every cycle until `dm_ready`=1.
  - On ready, sw goes to FETCH and lw goes to WB.
  - ALU controls are held stable throughout MEM.
- WB: `rf_wr`=1.
  - lw: `wd_sel`=1, `reg_dst`=0.
  - R-type: `reg_dst`=1, `wd_sel`=0.
  - I-type: `reg_dst`=0, `wd_sel`=0.
  - Go to FETCH.
- `retired` increments by 1 on each transition into FETCH from DCD, EXE, MEM or WB, including illegal instructions. It wraps at 2^CNT_W−1 → 0.

## Timing
- Reset:
  - `state`=FETCH; `retired`=0.
  - All enables (`pc_wr`, `ir_wr`, `rf_wr`, `dm_rd`, `dm_wr`, `illegal`) are forced 0 while `rst`=1.
  - All select outputs are 0.
  - The first fetch happens in the first cycle with `rst`=0.
- Reset mid-operation: the next edge returns the FSM to FETCH. Outstanding `dm_rd`/`dm_wr` drop in the same cycle `rst` rises, and the aborted instruction is not counted.
- CPI without wait states:
  - j/jal/jr/illegal: 2
  - beq: 3
  - sw, R-type, I-type: 4
  - lw: 5
- Each cycle of `dm_ready`=0 in MEM adds one cycle.
- `dm_ready` asserted in the same cycle the request is raised completes with zero wait. `dm_ready` outside MEM is ignored.
- `rf_wr` is never asserted for more than one cycle per instruction. `pc_wr` is asserted at most twice per instruction (FETCH plus jump/branch).

## Structure
- Shared package `mc_ctrl_pkg`:
  - state encodings.
  - `alu_op` codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
  - `npc_sel`, `reg_dst`, `wd_sel`, `ext_op` codes.
  - opcode and funct constants.
- The existing ALU is extended to this 3-bit `alu_op`.
- One sub-module `mc_decode`: combinational op/funct → instruction class (RTYPE, ITYPE, LOAD, STORE, BEQ, J, JAL, JR, ILLEGAL) plus `alu_op`/`ext_op`/`alu_src`. The FSM itself stays in `mc_ctrl`.

## Test plan
- Reset: hold `rst` 3 cycles → `state`=0, `retired`=0, all enables 0. First cycle after release: `ir_wr`=`pc_wr`=1.
- addu ($op=0, funct=100001) → state sequence 0,1,2,4,0. WB cycle drives `rf_wr`=1, `reg_dst`=1, `wd_sel`=0. `retired`=1 after 4 cycles.
- lw with `dm_ready` low 3 cycles → `dm_rd` held 4 cycles in MEM. Then WB with `wd_sel`=1, `reg_dst`=0. Total 8 cycles.
- beq:
  - `zero`=1 → EXE drives `pc_wr`=1, `npc_sel`=1.
  - `zero`=0 → `pc_wr`=0.
  - Both cases return to FETCH after 3 cycles.
- jal → DCD drives `pc_wr`=1, `npc_sel`=2, `rf_wr`=1, `reg_dst`=2, `wd_sel`=2. op=111111 → `illegal` pulses 1 cycle. Both take 2 cycles.
- sw waiting in MEM with `dm_ready`=0, `rst` raised → `dm_wr` drops same cycle, `state`=0 next edge, `retired` unchanged.
